// File: rtl/aging_scheduler.sv
// Aging sweep scheduler: a prescaled period timer launches sweeps that walk every
// hash bucket with one aging_req/aging_ack handshake each, yielding to frame lookups.
module aging_scheduler #(
    parameter int TICK_CYCLES  = 100000,
    parameter int PERIOD_TICKS = 300,
    parameter int ADDR_W       = 10,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              se_req,
    output logic              aging_req,
    output logic [ADDR_W-1:0] aging_addr,
    input  logic              aging_ack,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              timeout_err,
    output logic              overrun,
    output logic [15:0]       sweep_count
);

    localparam int PW = $clog2(TICK_CYCLES);
    localparam int QW = (PERIOD_TICKS > 1) ? $clog2(PERIOD_TICKS) : 1;
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [QW-1:0] PERIOD_LAST = QW'(PERIOD_TICKS - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        REQ  = 3'd2,
        NEXT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t          state, state_next;
    logic [PW-1:0]   presc;
    logic [QW-1:0]   period;
    logic [TW-1:0]   to_cnt;
    logic            pending;
    logic            tick, expire, start, timeout_hit, addr_last;

    assign tick        = (presc == PRESC_LAST);
    assign expire      = tick && (period == PERIOD_LAST);
    assign addr_last   = (aging_addr == {ADDR_W{1'b1}});
    assign timeout_hit = (state == REQ) && !aging_ack && (to_cnt == TO_LAST);
    assign start       = (state == IDLE) && (state_next == WAIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (pending && enable) state_next = WAIT;
            WAIT: begin
                if (!enable)      state_next = IDLE;
                else if (!se_req) state_next = REQ;
            end
            // Once raised, the request is held until ack or timeout regardless of se_req/enable.
            REQ:  if (aging_ack || to_cnt == TO_LAST) state_next = NEXT;
            NEXT: state_next = addr_last ? DONE : WAIT;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            period      <= '0;
            to_cnt      <= '0;
            pending     <= 1'b0;
            aging_req   <= 1'b0;
            aging_addr  <= '0;
            sweep_busy  <= 1'b0;
            sweep_done  <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
            sweep_count <= '0;
        end else begin
            state <= state_next;
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) period <= (period == PERIOD_LAST) ? '0 : period + 1'b1;

            // A fresh expiry wins over the sweep start consuming the previous one.
            if (expire)     pending <= 1'b1;
            else if (start) pending <= 1'b0;
            overrun <= expire && (pending || sweep_busy);

            if (state != REQ) to_cnt <= '0;
            else              to_cnt <= to_cnt + 1'b1;

            if (start)                          aging_addr <= '0;
            else if (state == NEXT && !addr_last) aging_addr <= aging_addr + 1'b1;

            aging_req   <= (state_next == REQ);
            sweep_busy  <= (state_next == WAIT) || (state_next == REQ) || (state_next == NEXT);
            sweep_done  <= (state_next == DONE);
            timeout_err <= timeout_hit;
            if (state == NEXT && addr_last) sweep_count <= sweep_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_aging_scheduler.sv
// Directed bench for aging_scheduler with small timing parameters and a scripted
// aging_ack responder; expected values are worked out by hand from the cycle timeline.
module tb_aging_scheduler;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              se_req = 1'b0;
    logic              aging_ack = 1'b0;
    logic              aging_req;
    logic [ADDR_W-1:0] aging_addr;
    logic              sweep_busy, sweep_done, timeout_err, overrun;
    logic [15:0]       sweep_count;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int to_cnt = 0;
    int ov_cnt = 0;

    aging_scheduler #(
        .TICK_CYCLES (4),
        .PERIOD_TICKS(2),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .se_req     (se_req),
        .aging_req  (aging_req),
        .aging_addr (aging_addr),
        .aging_ack  (aging_ack),
        .sweep_busy (sweep_busy),
        .sweep_done (sweep_done),
        .timeout_err(timeout_err),
        .overrun    (overrun),
        .sweep_count(sweep_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle; tests compare deltas.
    always @(negedge clk) begin
        if (!rst) begin
            if (sweep_done === 1'b1)  done_cnt <= done_cnt + 1;
            if (timeout_err === 1'b1) to_cnt   <= to_cnt + 1;
            if (overrun === 1'b1)     ov_cnt   <= ov_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        se_req = 1'b0;
        aging_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (aging_req !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("req_seen", {31'd0, aging_req}, 32'd1);
    endtask

    // Waits for a request, acks it `delay` cycles after it is seen, returns the address.
    task automatic hs(input int delay, output logic [ADDR_W-1:0] a);
        int n;
        wait_req(n);
        a = aging_addr;
        repeat (delay) step();
        chk("req_held", {31'd0, aging_req}, 32'd1);
        aging_ack = 1'b1;
        step();
        aging_ack = 1'b0;
        chk("req_drop", {31'd0, aging_req}, 32'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sweep_done !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("done_seen", {31'd0, sweep_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, h, d0, t0, o0;
        logic [ADDR_W-1:0] a;
        logic flag;

        // Reset state
        do_reset();
        chk("reset_outputs", {9'd0, aging_req, aging_addr, sweep_busy, sweep_done,
                              timeout_err, overrun, sweep_count}, 32'd0);

        // Normal sweep, followed by exactly one catch-up sweep after overruns
        enable = 1'b1;
        d0 = done_cnt; t0 = to_cnt; o0 = ov_cnt;
        n = 0;
        while (aging_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("first_req_cycle", n, 10);
        for (int i = 0; i < 4; i++) begin
            hs(1, a);
            chk("sweep1_addr", {30'd0, a}, i);
        end
        wait_done();
        chk("sweep1_count", {16'd0, sweep_count}, 1);
        chk("sweep1_overruns", ov_cnt - o0, 2);
        for (int i = 0; i < 4; i++) begin
            hs(1, a);
            chk("sweep2_addr", {30'd0, a}, i);
        end
        wait_done();
        enable = 1'b0;
        repeat (30) step();
        chk("two_sweeps_count", {16'd0, sweep_count}, 2);
        chk("two_sweeps_done_pulses", done_cnt - d0, 2);
        chk("two_sweeps_no_timeout", to_cnt - t0, 0);
        chk("idle_not_busy", {31'd0, sweep_busy}, 0);
        aging_ack = 1'b1;
        step();
        aging_ack = 1'b0;
        step();
        chk("stray_ack_req", {31'd0, aging_req}, 0);
        chk("stray_ack_count", {16'd0, sweep_count}, 2);

        // se_req defers the request in WAIT but never withdraws one in REQ
        do_reset();
        enable = 1'b1;
        se_req = 1'b1;
        n = 0;
        while (sweep_busy !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("busy_cycle", n, 9);
        flag = 1'b0;
        repeat (20) begin
            step();
            if (aging_req !== 1'b0) flag = 1'b1;
        end
        chk("se_req_blocks", {31'd0, flag}, 0);
        se_req = 1'b0;
        step();
        chk("req_after_se_req", {31'd0, aging_req}, 1);
        se_req = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            step();
            if (aging_req !== 1'b1) flag = 1'b1;
        end
        chk("req_held_under_se_req", {31'd0, flag}, 0);
        aging_ack = 1'b1;
        step();
        aging_ack = 1'b0;
        se_req = 1'b0;
        chk("req_drop_after_ack", {31'd0, aging_req}, 0);
        for (int i = 1; i < 4; i++) begin
            hs(1, a);
            chk("se_sweep_addr", {30'd0, a}, i);
        end
        wait_done();
        enable = 1'b0;
        chk("se_sweep_count", {16'd0, sweep_count}, 1);

        // Address 2 never acked: timeout after 8 cycles, sweep continues
        do_reset();
        enable = 1'b1;
        d0 = done_cnt; t0 = to_cnt;
        hs(1, a);
        hs(1, a);
        wait_req(n);
        chk("to_addr", {30'd0, aging_addr}, 2);
        h = 0;
        while (aging_req === 1'b1 && h < 50) begin
            h++;
            step();
        end
        chk("to_req_high_cycles", h, 8);
        chk("to_err_pulse", {31'd0, timeout_err}, 1);
        hs(1, a);
        chk("to_next_addr", {30'd0, a}, 3);
        wait_done();
        enable = 1'b0;
        step();
        chk("to_err_count", to_cnt - t0, 1);
        chk("to_done_count", done_cnt - d0, 1);
        chk("to_sweep_count", {16'd0, sweep_count}, 1);

        // Ack on the same cycle the timeout would expire counts as an ack
        do_reset();
        enable = 1'b1;
        t0 = to_cnt;
        hs(7, a);
        enable = 1'b0;
        chk("edge_ack_no_err", {31'd0, timeout_err}, 0);
        repeat (3) step();
        chk("edge_ack_err_count", to_cnt - t0, 0);

        // Enable dropped during address 1: handshake completes, sweep aborts
        do_reset();
        enable = 1'b1;
        d0 = done_cnt;
        hs(1, a);
        wait_req(n);
        enable = 1'b0;
        hs(1, a);
        chk("abort_addr", {30'd0, a}, 1);
        repeat (3) step();
        chk("abort_busy", {31'd0, sweep_busy}, 0);
        chk("abort_req", {31'd0, aging_req}, 0);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_count", {16'd0, sweep_count}, 0);

        // Reset during an active request
        do_reset();
        enable = 1'b1;
        wait_req(n);
        rst = 1'b1;
        step();
        chk("rst_mid_req", {9'd0, aging_req, aging_addr, sweep_busy, sweep_done,
                            timeout_err, overrun, sweep_count}, 32'd0);
        rst = 1'b0;
        enable = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
